// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the LEGv8 instruction encoder/loader: op classes,
// opcode constants, field widths, FSM states and the encoder payload struct.
package instr_encoder_loader_pkg;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned IMM_W    = 26;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned D_IMM_W  = 9;
    localparam int unsigned CB_IMM_W = 19;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_ORR  = 3'd3,
        OP_LDUR = 3'd4,
        OP_STUR = 3'd5,
        OP_CBZ  = 3'd6,
        OP_B    = 3'd7
    } op_class_e;

    localparam logic [10:0] OPC_ADD  = 11'h458;
    localparam logic [10:0] OPC_SUB  = 11'h658;
    localparam logic [10:0] OPC_AND  = 11'h450;
    localparam logic [10:0] OPC_ORR  = 11'h550;
    localparam logic [10:0] OPC_LDUR = 11'h7C2;
    localparam logic [10:0] OPC_STUR = 11'h7C0;
    localparam logic [7:0]  OPC_CBZ  = 8'hB4;
    localparam logic [5:0]  OPC_B    = 6'h05;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        op_class_e          op;
        logic [REG_W-1:0]   rd;
        logic [REG_W-1:0]   rn;
        logic [REG_W-1:0]   rm;
        logic [IMM_W-1:0]   imm;
    } instr_fields_t;

    // True when imm, read as signed, is representable in a width-bit signed field.
    function automatic logic fits_signed(logic [IMM_W-1:0] imm, int unsigned width);
        logic signed [IMM_W-1:0] s;
        logic signed [IMM_W-1:0] sh;
        s  = $signed(imm);
        sh = s >>> (width - 1);
        return (sh == '0) || (sh == '1);
    endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Instruction-beat stream (valid/ready plus LEGv8 fields) from the host command path.
interface instr_encoder_loader_if;
    import instr_encoder_loader_pkg::*;

    logic             in_valid;
    logic             in_ready;
    op_class_e        in_op;
    logic [REG_W-1:0] in_rd;
    logic [REG_W-1:0] in_rn;
    logic [REG_W-1:0] in_rm;
    logic [IMM_W-1:0] in_imm;
    logic             in_last;

    modport master (
        output in_valid, in_op, in_rd, in_rn, in_rm, in_imm, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rn, in_rm, in_imm, in_last,
        output in_ready
    );

endinterface

// File: rtl/instr_format_encoder.sv
// Combinational LEGv8 field-to-machine-word encoder with immediate range check.
module instr_format_encoder
    import instr_encoder_loader_pkg::*;
(
    input  instr_fields_t      fields,
    output logic [WORD_W-1:0]  word,
    output logic               range_ok
);

    always_comb begin
        word     = '0;
        range_ok = 1'b1;
        case (fields.op)
            OP_ADD:  word = {OPC_ADD, fields.rm, 6'b0, fields.rn, fields.rd};
            OP_SUB:  word = {OPC_SUB, fields.rm, 6'b0, fields.rn, fields.rd};
            OP_AND:  word = {OPC_AND, fields.rm, 6'b0, fields.rn, fields.rd};
            OP_ORR:  word = {OPC_ORR, fields.rm, 6'b0, fields.rn, fields.rd};
            OP_LDUR, OP_STUR: begin
                word     = {(fields.op == OP_LDUR) ? OPC_LDUR : OPC_STUR,
                            fields.imm[D_IMM_W-1:0], 2'b00, fields.rn, fields.rd};
                range_ok = fits_signed(fields.imm, D_IMM_W);
            end
            OP_CBZ: begin
                word     = {OPC_CBZ, fields.imm[CB_IMM_W-1:0], fields.rd};
                range_ok = fits_signed(fields.imm, CB_IMM_W);
            end
            OP_B:    word = {OPC_B, fields.imm};
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes a stream of LEGv8 instruction beats and writes them to sequential
// imem words from address 0; one registered write per accepted in-range beat.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    instr_encoder_loader_if.slave  in_if,
    output logic                   imem_we,
    output logic [ADDR_W-1:0]      imem_addr,
    output logic [WORD_W-1:0]      imem_wdata,
    output logic [ADDR_W:0]        word_count,
    output logic                   busy,
    output logic                   done,
    output logic                   err_range,
    output logic                   err_full
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CAPACITY = CNT_W'(1) << ADDR_W;

    state_e              state_q, state_d;
    logic                ready_q, ready_d;
    logic                we_d;
    logic [ADDR_W-1:0]   waddr_d;
    logic [WORD_W-1:0]   wdata_d;
    logic [CNT_W-1:0]    count_d;
    logic                busy_d, done_d, err_range_d, err_full_d;
    logic                accept;
    instr_fields_t       fields;
    logic [WORD_W-1:0]   word;
    logic                range_ok;

    assign fields = '{op: in_if.in_op, rd: in_if.in_rd, rn: in_if.in_rn,
                      rm: in_if.in_rm, imm: in_if.in_imm};
    assign accept = ready_q && in_if.in_valid;
    assign in_if.in_ready = ready_q;

    instr_format_encoder u_encoder (
        .fields   (fields),
        .word     (word),
        .range_ok (range_ok)
    );

    // Next state, write stage and counters; the write address is the running word count.
    always_comb begin
        state_d     = state_q;
        count_d     = word_count;
        we_d        = 1'b0;
        waddr_d     = imem_addr;
        wdata_d     = imem_wdata;
        done_d      = done;
        err_range_d = err_range;
        err_full_d  = err_full;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    count_d     = '0;
                    done_d      = 1'b0;
                    err_range_d = 1'b0;
                    err_full_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (range_ok) begin
                        we_d    = 1'b1;
                        waddr_d = word_count[ADDR_W-1:0];
                        wdata_d = word;
                        count_d = word_count + CNT_W'(1);
                    end else begin
                        err_range_d = 1'b1;
                    end
                    if (in_if.in_last) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (count_d == CAPACITY) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        err_full_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d  = (state_d == ST_LOAD);
        ready_d = busy_d && (count_d < CAPACITY);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            word_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_range  <= 1'b0;
            err_full   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            imem_we    <= we_d;
            imem_addr  <= waddr_d;
            imem_wdata <= wdata_d;
            word_count <= count_d;
            busy       <= busy_d;
            done       <= done_d;
            err_range  <= err_range_d;
            err_full   <= err_full_d;
        end
    end

endmodule
